cmac_bp_reader: RTL and testbench

AXI4-Lite register front end for the CMAC backpressure event FIFO. It presents the FIFO head entry (length, rx-alignment-dropped flag, 64-bit timestamp) to software as a coherent snapshot, and generates the edge-style `fifo_next` pop pulse the FIFO owner expects. It sits directly downstream of the backpressure monitor, between its FIFO output ports and the control-plane AXI interconnect.

---
 rtl/cmac_bp_reader.sv | 239 +++++++++++++++++++++++
 tb/tb_cmac_bp_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_bp_reader.sv
// AXI4-Lite front end for the CMAC backpressure event FIFO: coherent head snapshot plus pop pulse.
// Optional interrupt (irq port, IRQ_CTRL at 0x1C) is built only when CMAC_BPR_IRQ_EN is defined.
module cmac_bp_reader #(
  parameter int unsigned AW        = 5,
  parameter int unsigned NEXT_HOLD = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] s_axi_awaddr,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [31:0]   s_axi_wdata,
  input  logic [3:0]    s_axi_wstrb,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  output logic [1:0]    s_axi_bresp,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  input  logic [AW-1:0] s_axi_araddr,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [31:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  input  logic [31:0]   fifo_bp_length,
  input  logic          fifo_bp_rxad,
  input  logic [63:0]   fifo_bp_ts,
  input  logic          fifo_valid,
  output logic          fifo_next
`ifdef CMAC_BPR_IRQ_EN
  ,
  output logic          irq
`endif
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [3:0] HoldLast = 4'(NEXT_HOLD - 1);

  state_e        state_q, state_d;
  logic [3:0]    hold_q, hold_d;
  logic          awready_q, wready_q, bvalid_q, aw_held_q, w_held_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] awaddr_q, araddr_q;
  logic [31:0]   wdata_q;
  logic          arready_q, ar_pend_q, rvalid_q;
  logic [1:0]    rresp_q;
  logic [31:0]   rdata_q;
  logic [31:0]   snap_len_q, pop_count_q;
  logic          snap_rxad_q, snap_valid_q, fifo_next_q, irq_en_q;
  logic [63:0]   snap_ts_q;

  logic       wr_fire, b_hs, ar_hs, r_hs, pop_busy, pop_req, pop_accept, cnt_clear, wr_mapped;
  logic [2:0] wr_word, rd_word;
  logic [31:0] rd_data;
  logic       rd_err;
  logic       unused_bits;

  assign unused_bits = ^{s_axi_wstrb, wdata_q[31:1], awaddr_q[1:0], araddr_q[1:0]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign fifo_next     = fifo_next_q;

  // Side effects fire once, on the edge where bvalid rises.
  assign wr_fire    = aw_held_q && w_held_q && !bvalid_q;
  assign b_hs       = bvalid_q && s_axi_bready;
  assign ar_hs      = s_axi_arvalid && arready_q;
  assign r_hs       = rvalid_q && s_axi_rready;
  assign wr_word    = awaddr_q[4:2];
  assign rd_word    = araddr_q[4:2];
  assign pop_busy   = (state_q != StIdle);
  assign pop_req    = wr_fire && (wr_word == 3'd1) && wdata_q[0];
  assign pop_accept = pop_req && !pop_busy && fifo_valid;
  assign cnt_clear  = wr_fire && (wr_word == 3'd6);
`ifdef CMAC_BPR_IRQ_EN
  assign wr_mapped  = 1'b1;
`else
  assign wr_mapped  = (wr_word != 3'd7);
`endif

  always_comb begin
    rd_data = 32'd0;
    rd_err  = 1'b0;
    case (rd_word)
      3'd0: rd_data = {29'd0, pop_busy, snap_valid_q, fifo_valid};
      3'd2: rd_data = snap_len_q;
      3'd3: rd_data = {31'd0, snap_rxad_q};
      3'd4: rd_data = snap_ts_q[31:0];
      3'd5: rd_data = snap_ts_q[63:32];
      3'd6: rd_data = pop_count_q;
`ifdef CMAC_BPR_IRQ_EN
      3'd7: rd_data = {31'd0, irq_en_q};
`else
      3'd7: rd_err  = 1'b1;
`endif
      default: rd_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: if (pop_accept) begin
        state_d = StHigh;
        hold_d  = 4'd0;
      end
      StHigh: if (hold_q == HoldLast) begin
        state_d = StLow;
        hold_d  = 4'd0;
      end else begin
        hold_d = hold_q + 4'd1;
      end
      StLow: if (hold_q == 4'd1) begin
        state_d = StIdle;
      end else begin
        hold_d = hold_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= 32'd0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      if (b_hs) begin
        aw_held_q <= 1'b0;
        awready_q <= 1'b1;
      end else if (s_axi_awvalid && awready_q) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi_awaddr;
        awready_q <= 1'b0;
      end else if (!aw_held_q && !bvalid_q) begin
        awready_q <= 1'b1;
      end
      if (b_hs) begin
        w_held_q <= 1'b0;
        wready_q <= 1'b1;
      end else if (s_axi_wvalid && wready_q) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi_wdata;
        wready_q <= 1'b0;
      end else if (!w_held_q && !bvalid_q) begin
        wready_q <= 1'b1;
      end
      if (b_hs) begin
        bvalid_q <= 1'b0;
      end else if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? 2'b00 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      arready_q <= 1'b0;
      ar_pend_q <= 1'b0;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else if (r_hs) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else if (ar_hs) begin
      arready_q <= 1'b0;
      ar_pend_q <= 1'b1;
      araddr_q  <= s_axi_araddr;
    end else if (ar_pend_q) begin
      ar_pend_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_data;
      rresp_q   <= rd_err ? 2'b10 : 2'b00;
    end else if (!rvalid_q) begin
      arready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      hold_q       <= 4'd0;
      fifo_next_q  <= 1'b0;
      snap_len_q   <= 32'd0;
      snap_rxad_q  <= 1'b0;
      snap_ts_q    <= 64'd0;
      snap_valid_q <= 1'b0;
      pop_count_q  <= 32'd0;
      irq_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      fifo_next_q <= (state_q == StHigh);
      if (pop_req && !pop_busy) begin
        snap_valid_q <= fifo_valid;
        if (fifo_valid) begin
          snap_len_q  <= fifo_bp_length;
          snap_rxad_q <= fifo_bp_rxad;
          snap_ts_q   <= fifo_bp_ts;
        end
      end
      if (cnt_clear) begin
        pop_count_q <= 32'd0;
      end else if (pop_accept) begin
        pop_count_q <= pop_count_q + 32'd1;
      end
`ifdef CMAC_BPR_IRQ_EN
      if (wr_fire && (wr_word == 3'd7)) irq_en_q <= wdata_q[0];
`endif
    end
  end

`ifdef CMAC_BPR_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (!resetn) irq_q <= 1'b0;
    else         irq_q <= irq_en_q && fifo_valid && !pop_busy;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_cmac_bp_reader.sv
// Directed bench for cmac_bp_reader: register map, pop pulse timing, AXI write ordering, reset.
module tb_cmac_bp_reader;
  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] fifo_bp_length;
  logic        fifo_bp_rxad, fifo_valid, fifo_next;
  logic [63:0] fifo_bp_ts;
`ifdef CMAC_BPR_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cnt = 0, high_cnt = 0, rise_cyc = 0, bv_rise_cyc = 0, bv_rise_cnt = 0;
  logic prev_next = 1'b0, prev_bv = 1'b0;

  cmac_bp_reader #(.AW(5), .NEXT_HOLD(2)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .fifo_bp_length(fifo_bp_length), .fifo_bp_rxad(fifo_bp_rxad), .fifo_bp_ts(fifo_bp_ts),
    .fifo_valid(fifo_valid), .fifo_next(fifo_next)
`ifdef CMAC_BPR_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_next && !prev_next) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (fifo_next) high_cnt <= high_cnt + 1;
    if (s_axi_bvalid && !prev_bv) begin
      bv_rise_cnt <= bv_rise_cnt + 1;
      bv_rise_cyc <= cyc;
    end
    prev_next <= fifo_next;
    prev_bv   <= s_axi_bvalid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    logic aw_go, w_go, done;
    done = 1'b0;
    resp = 2'b11;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data;  s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_go) s_axi_awvalid = 1'b0;
      if (w_go)  s_axi_wvalid = 1'b0;
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    check("write_completes", done, 1);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic ar_go, done;
    done = 1'b0;
    data = 32'hdead_beef;
    resp = 2'b11;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      ar_go = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1;
      if (ar_go) s_axi_arvalid = 1'b0;
      if (s_axi_rvalid) begin
        data = s_axi_rdata;
        resp = s_axi_rresp;
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    check("read_completes", done, 1);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(tag, {d, 30'd0, r}, {exp_d, 30'd0, exp_r});
  endtask

  initial begin
    logic [1:0] resp;
    int r0, h0, b0;
    logic seen;

    resetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hf;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    fifo_bp_length = '0; fifo_bp_rxad = 1'b0; fifo_bp_ts = '0; fifo_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("reset_valids", {s_axi_bvalid, s_axi_rvalid, fifo_next}, 3'b000);
    check("reset_rdata", {s_axi_rdata, s_axi_rresp, s_axi_bresp}, 36'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    rd_check("status_reset", 5'h00, 32'd0, 2'b00);
    rd_check("popcount_reset", 5'h18, 32'd0, 2'b00);
`ifdef CMAC_BPR_IRQ_EN
    rd_check("irqctrl_reset", 5'h1C, 32'd0, 2'b00);
`else
    rd_check("unmapped_1c_read", 5'h1C, 32'd0, 2'b10);
    axi_write(5'h1C, 32'd1, resp);
    check("unmapped_1c_write", resp, 2'b10);
`endif

    // Accepted POP: snapshot, count, pulse timing.
    fifo_valid = 1'b1; fifo_bp_length = 32'h1234; fifo_bp_rxad = 1'b1;
    fifo_bp_ts = 64'h0000000A_00000005;
    r0 = rise_cnt; h0 = high_cnt;
    axi_write(5'h04, 32'd1, resp);
    check("pop_bresp", resp, 2'b00);
    fifo_bp_length = 32'h5555; fifo_bp_rxad = 1'b0; fifo_bp_ts = 64'h0000_0077_0000_0066;
    repeat (8) @(posedge clk);
    #1;
    check("pop_one_rise", rise_cnt - r0, 1);
    check("pop_hold_cycles", high_cnt - h0, 2);
    check("pop_rise_latency", rise_cyc - bv_rise_cyc, 1);
    rd_check("snap_len", 5'h08, 32'h1234, 2'b00);
    rd_check("snap_flags", 5'h0C, 32'd1, 2'b00);
    rd_check("snap_ts_lo", 5'h10, 32'd5, 2'b00);
    rd_check("snap_ts_hi", 5'h14, 32'hA, 2'b00);
    rd_check("popcount_1", 5'h18, 32'd1, 2'b00);
    rd_check("status_snap", 5'h00, 32'd3, 2'b00);
    rd_check("control_reads_0", 5'h04, 32'd0, 2'b00);

    // POP with empty FIFO.
    fifo_valid = 1'b0;
    r0 = rise_cnt;
    axi_write(5'h04, 32'd1, resp);
    check("empty_pop_bresp", resp, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    check("empty_pop_no_pulse", rise_cnt - r0, 0);
    rd_check("empty_pop_status", 5'h00, 32'd0, 2'b00);
    rd_check("empty_pop_count", 5'h18, 32'd1, 2'b00);
    rd_check("empty_pop_snap_kept", 5'h08, 32'h1234, 2'b00);

    // Back-to-back POPs: second lands while busy.
    fifo_valid = 1'b1; fifo_bp_length = 32'h777;
    r0 = rise_cnt;
    axi_write(5'h04, 32'd1, resp);
    fifo_bp_length = 32'h888;
    axi_write(5'h04, 32'd1, resp);
    check("busy_pop_okay", resp, 2'b00);
    repeat (8) @(posedge clk);
    #1;
    check("busy_pop_one_rise", rise_cnt - r0, 1);
    rd_check("busy_pop_count", 5'h18, 32'd2, 2'b00);
    rd_check("busy_pop_snap", 5'h08, 32'h777, 2'b00);

    // AW three cycles ahead of W, bready held off four cycles.
    fifo_bp_length = 32'h999;
    r0 = rise_cnt; b0 = bv_rise_cnt;
    @(negedge clk);
    s_axi_awaddr = 5'h04; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    check("aw_ready_drops", s_axi_awready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_axi_wdata = 32'd1; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (s_axi_bvalid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("late_w_bvalid", seen, 1);
    repeat (4) @(posedge clk);
    #1;
    check("bvalid_held", {s_axi_bvalid, s_axi_bresp}, 3'b100);
    check("readies_low_while_b", {s_axi_awready, s_axi_wready}, 2'b00);
    @(negedge clk);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_cleared", s_axi_bvalid, 0);
    check("readies_return", {s_axi_awready, s_axi_wready}, 2'b11);
    repeat (8) @(posedge clk);
    #1;
    check("late_w_single_b", bv_rise_cnt - b0, 1);
    check("late_w_one_rise", rise_cnt - r0, 1);
    rd_check("late_w_count", 5'h18, 32'd3, 2'b00);

    // Count clear and RO write.
    axi_write(5'h18, 32'hffff_ffff, resp);
    check("clear_bresp", resp, 2'b00);
    rd_check("count_cleared", 5'h18, 32'd0, 2'b00);
    axi_write(5'h08, 32'habcd, resp);
    check("ro_write_okay", resp, 2'b00);
    rd_check("ro_write_ignored", 5'h08, 32'h999, 2'b00);

`ifdef CMAC_BPR_IRQ_EN
    axi_write(5'h1C, 32'd1, resp);
    repeat (2) @(posedge clk);
    #1;
    check("irq_on", irq, 1);
    axi_write(5'h04, 32'd1, resp);
    check("irq_busy_low", irq, 0);
    repeat (8) @(posedge clk);
    #1;
    check("irq_back", irq, 1);
`endif

    // Reset mid-pulse.
    axi_write(5'h04, 32'd1, resp);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (fifo_next) seen = 1'b1;
    end
    check("pulse_before_reset", seen, 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("reset_kills_pulse", fifo_next, 0);
    check("reset_kills_ready", s_axi_awready, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    rd_check("count_after_reset", 5'h18, 32'd0, 2'b00);
    rd_check("status_after_reset", 5'h00, 32'd1, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    check("no_pulse_after_reset", fifo_next, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
